// File: rtl/mrv32_nport_mem.sv
// mrv32_nport_mem: N-port byte-addressed memory model for mrv32.
// Every port takes one word request per cycle with no backpressure and gets
// exactly one response per request, in order, RD_LATENCY cycles later.
// Writes are read-before-write, misaligned requests are rejected with an
// error response, and the lowest-index port wins each byte when writes collide.
// Port i occupies slice i of every packed bus.
module mrv32_nport_mem #(
    parameter int MEM_BYTES  = 65536,
    parameter int ADDR_WIDTH = 16,
    parameter int NUM_PORTS  = 2,
    parameter int RD_LATENCY = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_PORTS-1:0]       p_valid,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] p_addr,
    input  logic [NUM_PORTS*32-1:0]    p_wdata,
    input  logic [NUM_PORTS*4-1:0]     p_wstrb,
    output logic [NUM_PORTS*32-1:0]    p_rdata,
    output logic [NUM_PORTS-1:0]       p_rvalid,
    output logic [NUM_PORTS-1:0]       p_rerr
);

    localparam int IDX_W = $clog2(MEM_BYTES);

    // Byte storage; never reset, so a preload survives reset.
    logic [7:0] mem [0:MEM_BYTES-1];

    logic [NUM_PORTS-1:0] aligned;
    logic [NUM_PORTS-1:0] wen;
    logic [IDX_W-1:0]     base  [NUM_PORTS];
    logic [31:0]          rword [NUM_PORTS];

    // Response pipeline: stage 0 is loaded at the accepting edge, the
    // remaining RD_LATENCY stages delay it so stage RD_LATENCY drives the
    // outputs in the cycle following edge E+RD_LATENCY.
    logic [NUM_PORTS-1:0]    v_q [0:RD_LATENCY];
    logic [NUM_PORTS-1:0]    e_q [0:RD_LATENCY];
    logic [NUM_PORTS*32-1:0] d_q [0:RD_LATENCY];

    // Address bits above the storage size only select aliases (wrap-around).
    logic unused_addr;
    assign unused_addr = ^p_addr;

    // Per-port decode: wrapped byte index, alignment, write enable and the
    // current (pre-write) word at that address.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            base[i]    = p_addr[i*ADDR_WIDTH +: IDX_W];
            aligned[i] = (p_addr[i*ADDR_WIDTH +: 2] == 2'b00);
            wen[i]     = p_valid[i] && aligned[i] && !rst;
            rword[i]   = {mem[base[i] + IDX_W'(3)], mem[base[i] + IDX_W'(2)],
                          mem[base[i] + IDX_W'(1)], mem[base[i]]};
        end
    end

    // Byte writes; ports are scanned high to low so the lowest index is
    // assigned last and therefore wins any byte written by several ports.
    always_ff @(posedge clk) begin
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (wen[i]) begin
                for (int k = 0; k < 4; k++) begin
                    if (p_wstrb[i*4 + k]) begin
                        mem[base[i] + IDX_W'(k)] <= p_wdata[i*32 + 8*k +: 8];
                    end
                end
            end
        end
    end

    // Response pipeline: capture {valid, err, data} at acceptance and shift;
    // reset drops everything in flight immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s <= RD_LATENCY; s++) begin
                v_q[s] <= '0;
                e_q[s] <= '0;
                d_q[s] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                v_q[0][i]          <= p_valid[i];
                e_q[0][i]          <= p_valid[i] && !aligned[i];
                d_q[0][i*32 +: 32] <= (p_valid[i] && aligned[i]) ? rword[i] : 32'h0;
            end
            for (int s = 1; s <= RD_LATENCY; s++) begin
                v_q[s] <= v_q[s-1];
                e_q[s] <= e_q[s-1];
                d_q[s] <= d_q[s-1];
            end
        end
    end

    // Err and data are only ever non-zero alongside valid, so idle outputs
    // read as zero without extra masking.
    assign p_rvalid = v_q[RD_LATENCY];
    assign p_rerr   = e_q[RD_LATENCY];
    assign p_rdata  = d_q[RD_LATENCY];

endmodule

// File: tb/tb_mrv32_nport_mem.sv
// tb_mrv32_nport_mem: directed bench for mrv32_nport_mem.
// A 3-port latency-2 instance covers function, collisions, errors and reset;
// two 2-port instances (latency 1 and 5) share stimulus for streaming.
module tb_mrv32_nport_mem;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    // main instance: 3 ports, 4 KiB, 16-bit address, latency 2
    logic [2:0]  m_valid;
    logic [47:0] m_addr;
    logic [95:0] m_wdata;
    logic [11:0] m_wstrb;
    logic [95:0] m_rdata;
    logic [2:0]  m_rvalid;
    logic [2:0]  m_rerr;

    // streaming instances: 2 ports, 1 KiB, 12-bit address
    logic [1:0]  s_valid;
    logic [23:0] s_addr;
    logic [63:0] s_wdata;
    logic [7:0]  s_wstrb;
    logic [63:0] s1_rdata, s5_rdata;
    logic [1:0]  s1_rvalid, s5_rvalid;
    logic [1:0]  s1_rerr, s5_rerr;

    mrv32_nport_mem #(.MEM_BYTES(4096), .ADDR_WIDTH(16), .NUM_PORTS(3), .RD_LATENCY(2)) dut (
        .clk(clk), .rst(rst), .p_valid(m_valid), .p_addr(m_addr), .p_wdata(m_wdata),
        .p_wstrb(m_wstrb), .p_rdata(m_rdata), .p_rvalid(m_rvalid), .p_rerr(m_rerr));

    mrv32_nport_mem #(.MEM_BYTES(1024), .ADDR_WIDTH(12), .NUM_PORTS(2), .RD_LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst), .p_valid(s_valid), .p_addr(s_addr), .p_wdata(s_wdata),
        .p_wstrb(s_wstrb), .p_rdata(s1_rdata), .p_rvalid(s1_rvalid), .p_rerr(s1_rerr));

    mrv32_nport_mem #(.MEM_BYTES(1024), .ADDR_WIDTH(12), .NUM_PORTS(2), .RD_LATENCY(5)) dut_l5 (
        .clk(clk), .rst(rst), .p_valid(s_valid), .p_addr(s_addr), .p_wdata(s_wdata),
        .p_wstrb(s_wstrb), .p_rdata(s5_rdata), .p_rvalid(s5_rvalid), .p_rerr(s5_rerr));

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic m_req(input int p, input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        m_valid[p]         = 1'b1;
        m_addr[p*16 +: 16] = a;
        m_wdata[p*32 +: 32] = d;
        m_wstrb[p*4 +: 4]  = s;
    endtask

    task automatic m_idle();
        m_valid = '0;
        m_addr  = '0;
        m_wdata = '0;
        m_wstrb = '0;
    endtask

    task automatic s_req(input int p, input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        s_valid[p]          = 1'b1;
        s_addr[p*12 +: 12]  = a;
        s_wdata[p*32 +: 32] = d;
        s_wstrb[p*4 +: 4]   = s;
    endtask

    task automatic s_idle();
        s_valid = '0;
        s_addr  = '0;
        s_wdata = '0;
        s_wstrb = '0;
    endtask

    function automatic logic [31:0] pat(input int n);
        logic [7:0] b;
        b = 8'(n);
        return {8'hA5, b, 8'(n * 17), 8'(255 - n)};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        m_idle();
        s_idle();
        tick();
        tick();
        n_vec++; if (m_rvalid !== 3'b000) begin n_err++; $display("FAIL reset_rvalid: got %b expected 000", m_rvalid); end
        n_vec++; if (m_rerr !== 3'b000) begin n_err++; $display("FAIL reset_rerr: got %b expected 000", m_rerr); end
        n_vec++; if (m_rdata !== 96'h0) begin n_err++; $display("FAIL reset_rdata: got %h expected 0", m_rdata); end
        n_vec++; if ({s1_rvalid, s5_rvalid, s1_rdata, s5_rdata} !== '0) begin n_err++; $display("FAIL reset_stream_outputs: got nonzero expected 0"); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // known contents: 0x40 = 0x11223344, 0x80 = 0, 0x100 = 0xCAFEBABE
    task automatic setup_mem();
        m_req(0, 16'h0040, 32'h1122_3344, 4'hF);
        m_req(1, 16'h0080, 32'h0000_0000, 4'hF);
        m_req(2, 16'h0100, 32'hCAFE_BABE, 4'hF);
        tick();
        m_idle();
        repeat (3) tick();
    endtask

    task automatic test_latency();
        m_req(0, 16'h0040, 32'h0, 4'h0);
        tick();
        m_idle();
        n_vec++; if (m_rvalid !== 3'b000) begin n_err++; $display("FAIL lat_e0: got %b expected 000", m_rvalid); end
        tick();
        n_vec++; if (m_rvalid !== 3'b000) begin n_err++; $display("FAIL lat_e1: got %b expected 000", m_rvalid); end
        tick();
        n_vec++; if (m_rvalid !== 3'b001) begin n_err++; $display("FAIL lat_e2_valid: got %b expected 001", m_rvalid); end
        n_vec++; if (m_rdata[31:0] !== 32'h1122_3344) begin n_err++; $display("FAIL lat_e2_data: got %h expected 11223344", m_rdata[31:0]); end
        n_vec++; if (m_rerr !== 3'b000) begin n_err++; $display("FAIL lat_e2_err: got %b expected 000", m_rerr); end
        tick();
        n_vec++; if (m_rvalid !== 3'b000 || m_rdata !== 96'h0) begin n_err++; $display("FAIL lat_idle: got v=%b d=%h expected 0", m_rvalid, m_rdata); end
    endtask

    task automatic test_partial_write();
        m_req(1, 16'h0080, 32'hAABB_CCDD, 4'b0101);
        tick();
        m_idle();
        m_req(0, 16'h0080, 32'h0, 4'h0);
        tick();
        m_idle();
        tick();
        n_vec++; if (m_rvalid !== 3'b010 || m_rerr !== 3'b000) begin n_err++; $display("FAIL pw_ack: got v=%b e=%b expected 010/000", m_rvalid, m_rerr); end
        n_vec++; if (m_rdata[63:32] !== 32'h0) begin n_err++; $display("FAIL pw_ack_data: got %h expected 0", m_rdata[63:32]); end
        tick();
        n_vec++; if (m_rvalid !== 3'b001) begin n_err++; $display("FAIL pw_read_valid: got %b expected 001", m_rvalid); end
        n_vec++; if (m_rdata[31:0] !== 32'h00BB_00DD) begin n_err++; $display("FAIL pw_read_data: got %h expected 00bb00dd", m_rdata[31:0]); end
    endtask

    task automatic test_collision();
        m_req(0, 16'h0100, 32'h0102_0304, 4'hF);
        m_req(1, 16'h0100, 32'hF0F0_F0F0, 4'hF);
        m_req(2, 16'h0100, 32'h0, 4'h0);
        tick();
        m_idle();
        m_req(0, 16'h0100, 32'h0, 4'h0);
        tick();
        m_idle();
        tick();
        n_vec++; if (m_rvalid !== 3'b111) begin n_err++; $display("FAIL col_valid: got %b expected 111", m_rvalid); end
        n_vec++; if (m_rdata !== {3{32'hCAFE_BABE}}) begin n_err++; $display("FAIL col_old_word: got %h expected 3x cafebabe", m_rdata); end
        tick();
        n_vec++; if (m_rdata[31:0] !== 32'h0102_0304) begin n_err++; $display("FAIL col_winner: got %h expected 01020304", m_rdata[31:0]); end
        // partial overlap: port 0 byte 0 beats port 1, port 1 keeps bytes 1..3
        m_req(0, 16'h0100, 32'h0000_00AA, 4'b0001);
        m_req(1, 16'h0100, 32'h5566_7788, 4'hF);
        tick();
        m_idle();
        m_req(2, 16'h0100, 32'h0, 4'h0);
        tick();
        m_idle();
        tick();
        n_vec++; if (m_rdata[63:32] !== 32'h0102_0304) begin n_err++; $display("FAIL col2_ack: got %h expected 01020304", m_rdata[63:32]); end
        tick();
        n_vec++; if (m_rdata[95:64] !== 32'h5566_77AA) begin n_err++; $display("FAIL col2_merge: got %h expected 556677aa", m_rdata[95:64]); end
    endtask

    task automatic test_misaligned_wrap();
        m_req(2, 16'h0103, 32'hDEAD_BEEF, 4'hF);
        m_req(1, 16'h1040, 32'h0, 4'h0);
        m_req(0, 16'h0041, 32'h0, 4'h0);
        tick();
        m_idle();
        m_req(0, 16'h0100, 32'h0, 4'h0);
        tick();
        m_idle();
        tick();
        n_vec++; if (m_rvalid !== 3'b111 || m_rerr !== 3'b101) begin n_err++; $display("FAIL mis_flags: got v=%b e=%b expected 111/101", m_rvalid, m_rerr); end
        n_vec++; if (m_rdata[95:64] !== 32'h0 || m_rdata[31:0] !== 32'h0) begin n_err++; $display("FAIL mis_data: got %h expected 0 on ports 0,2", m_rdata); end
        n_vec++; if (m_rdata[63:32] !== 32'h1122_3344) begin n_err++; $display("FAIL wrap_read: got %h expected 11223344", m_rdata[63:32]); end
        tick();
        n_vec++; if (m_rdata[31:0] !== 32'h5566_77AA || m_rerr !== 3'b000) begin n_err++; $display("FAIL mis_unchanged: got %h e=%b expected 556677aa/000", m_rdata[31:0], m_rerr); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a [4];
        logic [31:0] e [4];
        a = '{16'h0040, 16'h0080, 16'h0100, 16'h1040};
        e = '{32'h1122_3344, 32'h00BB_00DD, 32'h5566_77AA, 32'h1122_3344};
        for (int c = 0; c < 7; c++) begin
            m_idle();
            if (c < 4) m_req(0, a[c], 32'h0, 4'h0);
            tick();
            if (c >= 2 && c < 6) begin
                n_vec++;
                if (m_rvalid !== 3'b001 || m_rdata[31:0] !== e[c-2]) begin
                    n_err++; $display("FAIL b2b_%0d: got v=%b d=%h expected 001/%h", c - 2, m_rvalid, m_rdata[31:0], e[c-2]);
                end
            end else begin
                n_vec++;
                if (m_rvalid !== 3'b000) begin n_err++; $display("FAIL b2b_gap_%0d: got %b expected 000", c, m_rvalid); end
            end
        end
    endtask

    task automatic test_streaming();
        logic [65:0] exp1, exp5;
        int idx;
        for (int c = 0; c < 8; c++) begin
            s_req(0, 12'(32'h200 + 4 * c), pat(c), 4'hF);
            s_req(1, 12'(32'h200 + 4 * (c + 8)), pat(c + 8), 4'hF);
            tick();
        end
        s_idle();
        repeat (7) tick();
        for (int t = 0; t < 22; t++) begin
            s_idle();
            if (t < 16) begin
                s_req(0, 12'(32'h200 + 4 * t), 32'h0, 4'h0);
                s_req(1, 12'(32'h200 + 4 * (15 - t)), 32'h0, 4'h0);
            end
            tick();
            idx = t - 1;
            exp1 = (idx >= 0 && idx < 16) ? {2'b11, pat(15 - idx), pat(idx)} : 66'h0;
            idx = t - 5;
            exp5 = (idx >= 0 && idx < 16) ? {2'b11, pat(15 - idx), pat(idx)} : 66'h0;
            n_vec++;
            if ({s1_rvalid, s1_rdata} !== exp1 || s1_rerr !== 2'b00) begin
                n_err++; $display("FAIL stream_l1_t%0d: got %h e=%b expected %h", t, {s1_rvalid, s1_rdata}, s1_rerr, exp1);
            end
            n_vec++;
            if ({s5_rvalid, s5_rdata} !== exp5 || s5_rerr !== 2'b00) begin
                n_err++; $display("FAIL stream_l5_t%0d: got %h e=%b expected %h", t, {s5_rvalid, s5_rdata}, s5_rerr, exp5);
            end
        end
    endtask

    task automatic test_reset_midflight();
        m_req(0, 16'h0040, 32'h0, 4'h0);
        tick();
        m_idle();
        m_req(1, 16'h0040, 32'h0, 4'h0);
        m_req(2, 16'h0080, 32'h0, 4'h0);
        tick();
        m_idle();
        m_req(0, 16'h0100, 32'h0, 4'h0);
        tick();
        n_vec++; if (m_rvalid !== 3'b001) begin n_err++; $display("FAIL rst_pre_valid: got %b expected 001", m_rvalid); end
        m_idle();
        m_req(1, 16'h0080, 32'hFFFF_FFFF, 4'hF);
        #2;
        rst = 1'b1;
        #1;
        n_vec++; if (m_rvalid !== 3'b000 || m_rerr !== 3'b000 || m_rdata !== 96'h0) begin
            n_err++; $display("FAIL rst_async_clear: got v=%b e=%b d=%h expected 0", m_rvalid, m_rerr, m_rdata);
        end
        tick();
        m_idle();
        @(negedge clk);
        rst = 1'b0;
        m_req(0, 16'h0080, 32'h0, 4'h0);
        m_req(2, 16'h0040, 32'h0, 4'h0);
        tick();
        m_idle();
        n_vec++; if (m_rvalid !== 3'b000) begin n_err++; $display("FAIL rst_no_stale_0: got %b expected 000", m_rvalid); end
        tick();
        n_vec++; if (m_rvalid !== 3'b000) begin n_err++; $display("FAIL rst_no_stale_1: got %b expected 000", m_rvalid); end
        tick();
        n_vec++; if (m_rvalid !== 3'b101) begin n_err++; $display("FAIL rst_first_req: got %b expected 101", m_rvalid); end
        n_vec++; if (m_rdata[31:0] !== 32'h00BB_00DD) begin n_err++; $display("FAIL rst_write_dropped: got %h expected 00bb00dd", m_rdata[31:0]); end
        n_vec++; if (m_rdata[95:64] !== 32'h1122_3344) begin n_err++; $display("FAIL rst_preload_kept: got %h expected 11223344", m_rdata[95:64]); end
        tick();
        n_vec++; if (m_rvalid !== 3'b000) begin n_err++; $display("FAIL rst_tail: got %b expected 000", m_rvalid); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        setup_mem();
        test_latency();
        test_partial_write();
        test_collision();
        test_misaligned_wrap();
        test_back_to_back();
        test_streaming();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
